// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: start/operand/result handshake bundle for the bit-serial adder
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cin;
  logic [WIDTH-1:0] sum;
  logic cout;
  logic busy;
  logic done;
  modport master (output start, a, b, cin, input sum, cout, busy, done);
  modport slave (input start, a, b, cin, output sum, cout, busy, done);
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: area-minimal adder stepping one shared full-adder cell LSB-first
module half_addr (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_ctrl #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic c, p, g1, s, g2, nc;
  half_addr ha1 (.a(sa[0]), .b(sb[0]), .s(p), .c(g1));
  half_addr ha2 (.a(p), .b(c), .s(s), .c(g2));
  assign nc = g1 | g2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else if (state == RUN) begin
      bus.sum <= {s, bus.sum[WIDTH-1:1]};
      sa      <= {1'b0, sa[WIDTH-1:1]};
      sb      <= {1'b0, sb[WIDTH-1:1]};
      c       <= nc;
      cnt     <= cnt + 1'b1;
      if (cnt == LAST) begin
        state    <= DONE;
        bus.cout <= nc;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
      end
    end else begin
      // IDLE and DONE accept start identically, giving back-to-back throughput
      bus.done <= 1'b0;
      if (bus.start) begin
        state    <= RUN;
        sa       <= bus.a;
        sb       <= bus.b;
        c        <= bus.cin;
        cnt      <= '0;
        bus.busy <= 1'b1;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed vectors checked against a cycle-count model and literal results
module tb_serial_add_ctrl;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  serial_add_ctrl_if #(.WIDTH(W)) bus ();
  serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int left;
  logic m_done;
  logic [W:0] pend, m_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      left   <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      pend   <= '0;
    end else if (left != 0) begin
      left   <= left - 1;
      m_done <= (left == 1);
      if (left == 1) m_res <= pend;
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        left <= W;
        pend <= {1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cin);
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_busy", 64'(bus.busy), 64'(left != 0));
    chk("model_done", 64'(bus.done), 64'(m_done));
    if (left == 0) chk("model_result", 64'({bus.cout, bus.sum}), 64'(m_res));
  end

  task automatic wait_done(output int k);
    k = 1;
    while (!bus.done && k < 4 * W) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic op(input string n, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                    input logic tc, input logic [W-1:0] es, input logic ec);
    int k;
    bus.start = 1'b1;
    bus.a = ta;
    bus.b = tb_;
    bus.cin = tc;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(k);
    chk({n, "_latency"}, 64'(k), 64'(W + 1));
    chk({n, "_sum"}, 64'(bus.sum), 64'(es));
    chk({n, "_cout"}, 64'(bus.cout), 64'(ec));
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 64'({bus.cout, bus.sum, bus.busy, bus.done}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    @(negedge clk);
    op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    @(negedge clk);
    op("add_cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    chk("idle_hold", 64'({bus.cout, bus.sum}), 64'(9'h001));
    bus.start = 1'b1;
    bus.a = 8'h10;
    bus.b = 8'h20;
    bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(k);
    chk("ignored_start_sum", 64'({bus.cout, bus.sum}), 64'(9'h030));
    op("back_to_back", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'hAA;
    bus.b = 8'h55;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_reset", 64'({bus.cout, bus.sum, bus.busy, bus.done}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 64'({bus.busy, bus.done}), 64'(0));
    op("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
